core4_debug_port_arbiter: RTL and testbench

CORE4_DEBUG_PORT_ARBITER -- requirements
Module: core4_debug_port_arbiter

---
 rtl/core4_debug_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_core4_debug_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core4_debug_port_arbiter.sv
// Round-robin arbiter giving four requesters turns on one shared debug port.
// Optional wait-state timeout is built when CORE4_DBG_ARB_TIMEOUT_EN is defined.
module core4_debug_port_arbiter #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [3:0]            req_wr,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_wdata,
    output logic [3:0]            gnt,
    output logic [3:0]            done,
    output logic [3:0]            timeout_err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  port_valid,
    output logic                  port_wr,
    output logic [ADDR_W-1:0]     port_addr,
    output logic [DATA_W-1:0]     port_wdata,
    input  logic                  port_ready,
    input  logic [DATA_W-1:0]     port_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RELEASE = 2'd2} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          winner_reg, winner_next;
    logic [1:0]          last_granted_reg, last_granted_next;
    logic [3:0]          gnt_next, done_next;
    logic [DATA_W-1:0]   rdata_next, port_wdata_next;
    logic [ADDR_W-1:0]   port_addr_next;
    logic                port_valid_next, port_wr_next;
    logic [ADDR_W-1:0]   addr_arr  [4];
    logic [DATA_W-1:0]   wdata_arr [4];
    logic                pick_valid;
    logic [1:0]          pick;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from lowest to highest priority so the highest-priority request is assigned last.
    always_comb begin
        pick_valid = 1'b0;
        pick       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[last_granted_reg + 2'(k + 1)]) begin
                pick_valid = 1'b1;
                pick       = last_granted_reg + 2'(k + 1);
            end
        end
    end

`ifdef CORE4_DBG_ARB_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [3:0]  timeout_err_next;
`endif

    always_comb begin
        state_next        = state_reg;
        winner_next       = winner_reg;
        last_granted_next = last_granted_reg;
        gnt_next          = gnt;
        done_next         = 4'b0000;
        rdata_next        = rdata;
        port_valid_next   = port_valid;
        port_wr_next      = port_wr;
        port_addr_next    = port_addr;
        port_wdata_next   = port_wdata;
`ifdef CORE4_DBG_ARB_TIMEOUT_EN
        wait_cnt_next     = wait_cnt_reg;
        timeout_err_next  = 4'b0000;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next      = ACCESS;
                    winner_next     = pick;
                    gnt_next        = 4'b0001 << pick;
                    port_valid_next = 1'b1;
                    port_wr_next    = req_wr[pick];
                    port_addr_next  = addr_arr[pick];
                    port_wdata_next = wdata_arr[pick];
`ifdef CORE4_DBG_ARB_TIMEOUT_EN
                    wait_cnt_next   = 16'd0;
`endif
                end
            end
            ACCESS: begin
                // Completion is checked first so it wins over a timeout in the same cycle.
                if (port_ready) begin
                    state_next        = RELEASE;
                    gnt_next          = 4'b0000;
                    port_valid_next   = 1'b0;
                    done_next         = 4'b0001 << winner_reg;
                    last_granted_next = winner_reg;
                    if (!port_wr) begin
                        rdata_next = port_rdata;
                    end
                end
`ifdef CORE4_DBG_ARB_TIMEOUT_EN
                else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next        = RELEASE;
                    gnt_next          = 4'b0000;
                    port_valid_next   = 1'b0;
                    timeout_err_next  = 4'b0001 << winner_reg;
                    last_granted_next = winner_reg;
                    wait_cnt_next     = wait_cnt_reg + 16'd1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
`endif
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            winner_reg       <= 2'd0;
            last_granted_reg <= 2'd3;
            gnt              <= 4'b0000;
            done             <= 4'b0000;
            rdata            <= '0;
            port_valid       <= 1'b0;
            port_wr          <= 1'b0;
            port_addr        <= '0;
            port_wdata       <= '0;
        end else begin
            state_reg        <= state_next;
            winner_reg       <= winner_next;
            last_granted_reg <= last_granted_next;
            gnt              <= gnt_next;
            done             <= done_next;
            rdata            <= rdata_next;
            port_valid       <= port_valid_next;
            port_wr          <= port_wr_next;
            port_addr        <= port_addr_next;
            port_wdata       <= port_wdata_next;
        end
    end

`ifdef CORE4_DBG_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= 16'd0;
            timeout_err  <= 4'b0000;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            timeout_err  <= timeout_err_next;
        end
    end
`else
    assign timeout_err = 4'b0000;
`endif

endmodule

// File: tb/tb_core4_debug_port_arbiter.sv
// Bench for core4_debug_port_arbiter: directed scenarios then random transactions
// checked against a transaction-level round-robin model.
module tb_core4_debug_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req, req_wr;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata;
    logic [3:0]      gnt, done, timeout_err;
    logic [DW-1:0]   rdata;
    logic            port_valid, port_wr;
    logic [AW-1:0]   port_addr;
    logic [DW-1:0]   port_wdata;
    logic            port_ready;
    logic [DW-1:0]   port_rdata;

    core4_debug_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .timeout_err(timeout_err),
        .rdata(rdata), .port_valid(port_valid), .port_wr(port_wr), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_ready(port_ready), .port_rdata(port_rdata)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            txn_id   = 0;
    int            last     = 3;
    logic [DW-1:0] exp_rdata = '0;
    logic [AW-1:0] a_in [4];
    logic [DW-1:0] d_in [4];
    logic [3:0]    obs_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic load_inputs(input logic [3:0] r, input logic [3:0] wr);
        req    = r;
        req_wr = wr;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW]  = a_in[i];
            req_wdata[i*DW +: DW] = d_in[i];
        end
    endtask

    // mode 0: inputs steady; 1: scramble requester inputs during access; 2: drop req from 2nd cycle
    task automatic run_txn(input logic [3:0] r, input logic [3:0] wr, input int lat,
                           input logic [DW-1:0] rdv, input int mode);
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          wbit;
        w    = rr_pick(r);
        a    = a_in[w];
        d    = d_in[w];
        wbit = wr[w];
        load_inputs(r, wr);
        port_ready = 1'($urandom);
        tick();
        for (int c = 1; c <= lat; c++) begin
            port_ready = (c == lat);
            port_rdata = (c == lat) ? rdv : $urandom;
            if (mode == 1) begin
                req       = 4'($urandom);
                req_wr    = 4'($urandom);
                req_addr  = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (mode == 2 && c >= 2) begin
                req = 4'b0000;
            end
            if (c == 1) obs_gnt = gnt;
            chk("gnt_access", gnt, 4'b0001 << w);
            chk("port_valid_access", port_valid, 1);
            chk("port_wr_latched", port_wr, wbit);
            chk("port_addr_latched", port_addr, a);
            chk("port_wdata_latched", port_wdata, d);
            chk("done_during_access", done, 0);
            chk("timeout_err_during_access", timeout_err, 0);
            tick();
        end
        if (!wbit) exp_rdata = rdv;
        last = w;
        chk("done_pulse", done, 4'b0001 << w);
        chk("gnt_release", gnt, 0);
        chk("port_valid_release", port_valid, 0);
        chk("rdata_after_access", rdata, exp_rdata);
        chk("timeout_err_release", timeout_err, 0);
        port_ready = 1'b1;
        req        = 4'($urandom);
        tick();
        chk("done_idle", done, 0);
        chk("gnt_idle", gnt, 0);
        chk("port_valid_idle", port_valid, 0);
        chk("rdata_idle", rdata, exp_rdata);
        req        = 4'b0000;
        port_ready = 1'b0;
        $display("txn %0d: req=%b winner=%0d wr=%0b lat=%0d addr=0x%0h rdata=0x%0h",
                 txn_id, r, w, wbit, lat, a, rdata);
        txn_id++;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = AW'($urandom);
            d_in[i] = $urandom;
        end
    endtask

    initial begin
        int exp_order [5];
        int max_lat;
        exp_order = '{0, 1, 2, 3, 0};
        reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        port_ready = 1'b0; port_rdata = '0;
        rand_payload();
        tick(); tick();
        chk("reset_gnt", gnt, 0);
        chk("reset_port_valid", port_valid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_port_addr", port_addr, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;
        tick();

        // fairness from reset: all requesting, immediate ready
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            run_txn(4'b1111, 4'($urandom), 1, $urandom, 0);
            chk("fair_order", obs_gnt, 4'b0001 << exp_order[i]);
        end

        // walk last grant up to 3, then check wrap on 1001
        rand_payload();
        run_txn(4'b0010, 4'b0000, 1, $urandom, 0);
        run_txn(4'b0100, 4'b0000, 2, $urandom, 0);
        run_txn(4'b1000, 4'b1111, 1, $urandom, 0);
        run_txn(4'b1001, 4'b0000, 1, $urandom, 0);
        chk("wrap_first", obs_gnt, 4'b0001);
        run_txn(4'b1001, 4'b0000, 1, $urandom, 0);
        chk("wrap_second", obs_gnt, 4'b1000);

        // single read with ready on the third access cycle
        rand_payload();
        a_in[0] = 9'h100;
        run_txn(4'b0001, 4'b0000, 3, 32'hDEADBEEF, 0);
        chk("single_read_rdata", rdata, 32'hDEADBEEF);

        // write whose request drops mid-access
        rand_payload();
        run_txn(4'b0010, 4'b0010, 3, 32'h12345678, 2);
        chk("drop_write_rdata_kept", rdata, 32'hDEADBEEF);

`ifdef CORE4_DBG_ARB_TIMEOUT_EN
        begin
            int w;
            rand_payload();
            w = rr_pick(4'b0100);
            load_inputs(4'b0100, 4'b0000);
            tick();
            for (int c = 1; c <= 4; c++) begin
                port_ready = 1'b0;
                chk("to_port_valid", port_valid, 1);
                chk("to_no_err_yet", timeout_err, 0);
                tick();
            end
            last = w;
            chk("to_pulse", timeout_err, 4'b0001 << w);
            chk("to_no_done", done, 0);
            chk("to_port_valid_low", port_valid, 0);
            chk("to_rdata_kept", rdata, exp_rdata);
            req = 4'b0000;
            tick();
            chk("to_pulse_one_cycle", timeout_err, 0);
            $display("txn %0d: timeout of requester %0d", txn_id, w);
            txn_id++;
            rand_payload();
            run_txn(4'b1111, 4'b0000, 4, $urandom, 0);
        end
        max_lat = 4;
`else
        rand_payload();
        run_txn(4'b0100, 4'b0000, 20, $urandom, 0);
        max_lat = 6;
`endif

        // reset in the middle of requester 2's write access
        rand_payload();
        a_in[2] = 9'h1A5;
        d_in[2] = 32'hCAFEF00D;
        load_inputs(4'b0100, 4'b0100);
        tick();
        chk("rst_pre_gnt", gnt, 4'b0100);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_port_valid", port_valid, 0);
        chk("rst_mid_port_wr", port_wr, 0);
        chk("rst_mid_port_addr", port_addr, 0);
        chk("rst_mid_port_wdata", port_wdata, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_timeout_err", timeout_err, 0);
        req = 4'b0000;
        tick();
        reset     = 1'b0;
        last      = 3;
        exp_rdata = '0;
        tick();
        rand_payload();
        run_txn(4'b1111, 4'b0000, 1, $urandom, 0);
        chk("rst_next_grant", obs_gnt, 4'b0001);

        // random transactions against the model
        for (int n = 0; n < 40; n++) begin
            rand_payload();
            run_txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom_range(1, max_lat),
                    $urandom, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
